// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider
//  Description : Iterative unsigned restoring divider, one trial subtraction
//                per clock. start/busy/done handshake; results are held on
//                the outputs until they are overwritten by the next result.
//
//  Ports
//    clk          in   rising-edge clock
//    rst_n        in   asynchronous active-low reset
//    start        in   operation request, sampled only while busy=0
//    dividend     in   [WIDTH] unsigned dividend, captured on accept
//    divisor      in   [WIDTH] unsigned divisor, captured on accept
//    busy         out  high while an operation is in progress
//    done         out  one-cycle pulse, results valid
//    quotient     out  [WIDTH] quotient (all ones on divide by zero)
//    remainder    out  [WIDTH] remainder (dividend on divide by zero)
//    div_by_zero  out  set with done when the divisor was zero
//
//  Revision    : 1.0  initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int C_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_q;       // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   r_d;       // captured divisor
    // After every iteration the partial remainder is strictly less than the
    // divisor, so it always fits in WIDTH bits; only the shifted trial value
    // needs the extra bit.
    logic [WIDTH-1:0]   r_rem;
    logic [C_CNT_W-1:0] r_count;

    logic [WIDTH:0]     w_r_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_r_next;
    logic [WIDTH-1:0]   w_q_next;

    // One restoring step: shift {R,Q} left, try R - D, keep it if non-negative.
    assign w_r_shift = {r_rem, r_q[WIDTH-1]};
    assign w_trial   = w_r_shift - {1'b0, r_d};
    assign w_fits    = ~w_trial[WIDTH];
    assign w_r_next  = w_fits ? w_trial[WIDTH-1:0] : w_r_shift[WIDTH-1:0];
    assign w_q_next  = (r_q << 1) | WIDTH'(w_fits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                // IDLE and DONE both accept a new operation; DONE also ends
                // the done pulse here.
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_q         <= dividend;
                        r_d         <= divisor;
                        r_rem       <= '0;
                        r_count     <= C_CNT_W'(WIDTH);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        r_state     <= S_RUN;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end

                S_RUN: begin
                    if (r_d == '0) begin
                        // Zero divisor: skip the iterations and publish the
                        // saturated quotient on the first edge after accept.
                        quotient    <= '1;
                        remainder   <= r_q;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        r_count     <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_q     <= w_q_next;
                        r_rem   <= w_r_next;
                        r_count <= r_count - 1'b1;
                        // Final iteration: publish this step's values directly.
                        if (r_count == C_CNT_W'(1)) begin
                            quotient  <= w_q_next;
                            remainder <= w_r_next;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
